// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants and RGB444 pixel layout, shared by the
// sync generator and the renderer.
package vga_timing_pkg;

   localparam int unsigned VGA_H_SYNC  = 96;
   localparam int unsigned VGA_H_BP    = 48;
   localparam int unsigned VGA_H_ACT   = 640;
   localparam int unsigned VGA_H_FP    = 16;
   localparam int unsigned VGA_V_SYNC  = 2;
   localparam int unsigned VGA_V_BP    = 33;
   localparam int unsigned VGA_V_ACT   = 480;
   localparam int unsigned VGA_V_FP    = 10;

   localparam int unsigned VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BP + VGA_H_ACT + VGA_H_FP;
   localparam int unsigned VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BP + VGA_V_ACT + VGA_V_FP;
   localparam int unsigned VGA_H_START = VGA_H_SYNC + VGA_H_BP;
   localparam int unsigned VGA_V_START = VGA_V_SYNC + VGA_V_BP;

   localparam int unsigned POS_W    = 10;
   localparam int unsigned RGB_CH_W = 4;
   localparam int unsigned RGB_W    = 3 * RGB_CH_W;

   typedef struct packed {
      logic [RGB_CH_W-1:0] r;
      logic [RGB_CH_W-1:0] g;
      logic [RGB_CH_W-1:0] b;
   } rgb444_t;

   function automatic bit fits_pos(input int unsigned total);
      return total <= ((1 << POS_W) - 1);
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Renderer-facing bus: scan position and visible-window flag out, registered
// RGB444 pixel back in.
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   logic [POS_W-1:0] pos_H;
   logic [POS_W-1:0] pos_V;
   logic             ready;
   logic             frame_start;
   logic [RGB_W-1:0] RGB_in;

   modport master (output pos_H, output pos_V, output ready, output frame_start, input RGB_in);
   modport slave  (input pos_H, input pos_V, input ready, input frame_start, output RGB_in);

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with an asynchronous reset value; depth 0 is a
// straight combinational pass-through.
module vga_delay_line #(
   parameter int unsigned      DEPTH   = 1,
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             vga_CLK,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_thru
      logic unused_clk_rst;
      assign unused_clk_rst = vga_CLK ^ reset;
      assign q = d;
   end else begin : g_reg
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge vga_CLK or posedge reset) begin
         if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
         end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
         end
      end

      assign q = stage[DEPTH-1];
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters, sync/blank decode and pixel re-alignment towards the
// DAC pins; sync and colour leave PIPE_DLY+1 clocks after the counters.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned H_ACT    = VGA_H_ACT,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter int unsigned V_ACT    = VGA_V_ACT,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned PIPE_DLY = 1,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic                vga_CLK,
   input  logic                reset,
   vga_sync_gen_if.master      rend,
   output logic                hsync,
   output logic                vsync,
   output logic [RGB_CH_W-1:0] vga_R,
   output logic [RGB_CH_W-1:0] vga_G,
   output logic [RGB_CH_W-1:0] vga_B
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int unsigned H_START = H_SYNC + H_BP;
   localparam int unsigned V_START = V_SYNC + V_BP;

   localparam logic [POS_W-1:0] H_LAST  = POS_W'(H_TOTAL - 1);
   localparam logic [POS_W-1:0] V_LAST  = POS_W'(V_TOTAL - 1);
   localparam logic [POS_W-1:0] H_BEG   = POS_W'(H_START);
   localparam logic [POS_W-1:0] H_END   = POS_W'(H_START + H_ACT - 1);
   localparam logic [POS_W-1:0] V_BEG   = POS_W'(V_START);
   localparam logic [POS_W-1:0] V_END   = POS_W'(V_START + V_ACT - 1);
   localparam logic [POS_W-1:0] H_SY_END = POS_W'(H_SYNC);
   localparam logic [POS_W-1:0] V_SY_END = POS_W'(V_SYNC);

   if (!fits_pos(H_TOTAL) || !fits_pos(V_TOTAL)) begin : g_bad_total
      $error("vga_sync_gen: line/frame totals must fit in %0d bits", POS_W);
   end
   if (PIPE_DLY > 3) begin : g_bad_dly
      $error("vga_sync_gen: PIPE_DLY must be 0..3");
   end

   logic [POS_W-1:0] h_cnt, v_cnt;
   logic             hs_raw, vs_raw, ready_raw;
   logic             hs_d, vs_d, act_d;
   rgb444_t          pix;

   always_ff @(posedge vga_CLK or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_comb begin
      ready_raw = (h_cnt >= H_BEG) && (h_cnt <= H_END) &&
                  (v_cnt >= V_BEG) && (v_cnt <= V_END);
      hs_raw    = (h_cnt < H_SY_END) ? SYNC_POL : ~SYNC_POL;
      vs_raw    = (v_cnt < V_SY_END) ? SYNC_POL : ~SYNC_POL;
   end

   assign rend.pos_H       = h_cnt;
   assign rend.pos_V       = v_cnt;
   assign rend.ready       = ready_raw;
   assign rend.frame_start = ~reset && (h_cnt == '0) && (v_cnt == '0);

   // Delay matches the renderer's RGB latency so blanking lines up with its pixel.
   vga_delay_line #(
      .DEPTH   (PIPE_DLY),
      .WIDTH   (3),
      .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
   ) u_align (
      .vga_CLK (vga_CLK),
      .reset   (reset),
      .d       ({hs_raw, vs_raw, ready_raw}),
      .q       ({hs_d, vs_d, act_d})
   );

   assign pix = rend.RGB_in;

   always_ff @(posedge vga_CLK or posedge reset) begin
      if (reset) begin
         hsync <= ~SYNC_POL;
         vsync <= ~SYNC_POL;
         vga_R <= '0;
         vga_G <= '0;
         vga_B <= '0;
      end else begin
         hsync <= hs_d;
         vsync <= vs_d;
         if (act_d) begin
            vga_R <= pix.r;
            vga_G <= pix.g;
            vga_B <= pix.b;
         end else begin
            vga_R <= '0;
            vga_G <= '0;
            vga_B <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full 640x480 timing on one instance, plus two shrunken
// rasters at PIPE_DLY 0 and 3 for whole-frame counts and latency.
module tb_vga_sync_gen;
   import vga_timing_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #20 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   vga_sync_gen_if if_m ();
   vga_sync_gen_if if_s0 ();
   vga_sync_gen_if if_s3 ();

   logic       hs_m, vs_m, hs_s0, vs_s0, hs_s3, vs_s3;
   logic [3:0] r_m, g_m, b_m, r_s0, g_s0, b_s0, r_s3, g_s3, b_s3;

   vga_sync_gen #(.PIPE_DLY(1)) dut_m (
      .vga_CLK(clk), .reset(rst), .rend(if_m),
      .hsync(hs_m), .vsync(vs_m), .vga_R(r_m), .vga_G(g_m), .vga_B(b_m)
   );

   vga_sync_gen #(
      .H_SYNC(4), .H_BP(3), .H_ACT(8), .H_FP(2),
      .V_SYNC(2), .V_BP(2), .V_ACT(5), .V_FP(1), .PIPE_DLY(0)
   ) dut_s0 (
      .vga_CLK(clk), .reset(rst), .rend(if_s0),
      .hsync(hs_s0), .vsync(vs_s0), .vga_R(r_s0), .vga_G(g_s0), .vga_B(b_s0)
   );

   vga_sync_gen #(
      .H_SYNC(4), .H_BP(3), .H_ACT(8), .H_FP(2),
      .V_SYNC(2), .V_BP(2), .V_ACT(5), .V_FP(1), .PIPE_DLY(3)
   ) dut_s3 (
      .vga_CLK(clk), .reset(rst), .rend(if_s3),
      .hsync(hs_s3), .vsync(vs_s3), .vga_R(r_s3), .vga_G(g_s3), .vga_B(b_s3)
   );

   // One-clock registered renderer for the full-size instance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) if_m.RGB_in <= '0;
      else     if_m.RGB_in <= {if_m.pos_H[3:0], if_m.pos_V[3:0], 4'hA};
   end
   assign if_s0.RGB_in = 12'hFFF;
   assign if_s3.RGB_in = 12'hFFF;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   initial begin
      int k;
      int hs_fall[2];
      int hs_nf, hs_low_l0, vs_low, fs_cnt;
      logic prev_hs;
      logic [9:0] ph1, ph799, pv799, ph800, pv800;
      int w;
      int rdy_cnt, rdy_edge, fs_s, vs_low_s0, vs_low_s3;
      logic fs_end;
      logic [9:0] first_h, first_v, last_h, last_v;
      int rdy_rise, rdy_fall, hs0_f, hs3_f, c0_r, c0_f, c3_r, c3_f;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // mid-line asynchronous reset
      for (int i = 0; i < 1000 && if_m.pos_H != 10'd400; i++) @(negedge clk);
      check("pre_rst_pos_H", if_m.pos_H, 400);
      check("pre_rst_vsync", vs_m, 0);
      rst = 1'b1;
      #1;
      check("rst_pos_H", if_m.pos_H, 0);
      check("rst_pos_V", if_m.pos_V, 0);
      check("rst_hsync", hs_m, 1);
      check("rst_vsync", vs_m, 1);
      check("rst_rgb", {r_m, g_m, b_m}, 0);
      repeat (5) @(negedge clk);
      check("rst_hold_pos_H", if_m.pos_H, 0);
      check("rst_frame_start", if_m.frame_start, 0);
      check("rst_hold_ready", if_m.ready, 0);
      rst = 1'b0;
      #1;
      check("frame_start_k0", if_m.frame_start, 1);

      // free-run the first two lines and beyond the vsync pulse
      hs_fall[0] = -1; hs_fall[1] = -1;
      hs_nf = 0; hs_low_l0 = 0; vs_low = 0; fs_cnt = 0; prev_hs = hs_m;
      ph1 = '0; ph799 = '0; pv799 = '0; ph800 = '0; pv800 = '0;
      for (int kk = 1; kk <= 2000; kk++) begin
         @(negedge clk);
         if (prev_hs && !hs_m && hs_nf < 2) begin
            hs_fall[hs_nf] = kk;
            hs_nf++;
         end
         prev_hs = hs_m;
         if (!hs_m && kk < 800) hs_low_l0++;
         if (!vs_m) vs_low++;
         if (if_m.frame_start) fs_cnt++;
         if (kk == 1)   ph1 = if_m.pos_H;
         if (kk == 799) begin ph799 = if_m.pos_H; pv799 = if_m.pos_V; end
         if (kk == 800) begin ph800 = if_m.pos_H; pv800 = if_m.pos_V; end
      end
      check("first_clk_pos_H", ph1, 1);
      check("hsync_first_fall", hs_fall[0], 2);
      check("hsync_low_width", hs_low_l0, 96);
      check("hsync_second_fall", hs_fall[1], 802);
      check("pos_H_799", ph799, 799);
      check("pos_V_at_799", pv799, 0);
      check("pos_H_wrap", ph800, 0);
      check("pos_V_inc", pv800, 1);
      check("vsync_low_width", vs_low, 1600);
      check("frame_start_extra", fs_cnt, 0);

      // first visible pixel and end of the first visible line
      k = 2000;
      while (!if_m.ready && k < 30000) begin
         @(negedge clk);
         k++;
      end
      check("first_ready_k", k, 28144);
      check("first_ready_H", if_m.pos_H, 144);
      check("first_ready_V", if_m.pos_V, 35);
      @(negedge clk);
      check("porch_rgb", {r_m, g_m, b_m}, 0);
      @(negedge clk);
      check("pix0_R", r_m, 4'h0);
      check("pix0_G", g_m, 4'h3);
      check("pix0_B", b_m, 4'hA);
      repeat (637) @(negedge clk);
      check("last_ready_in_line", if_m.ready, 1);
      check("last_ready_H", if_m.pos_H, 783);
      @(negedge clk);
      check("ready_off_784", if_m.ready, 0);
      @(negedge clk);
      check("pix_last_R", r_m, 4'hF);
      check("pix_last_G", g_m, 4'h3);
      @(negedge clk);
      check("front_porch_rgb", {r_m, g_m, b_m}, 0);

      // whole frames on the shrunken rasters (17 x 10 clocks)
      w = 0;
      while (!if_s0.frame_start && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("small_fs_found", (w < 200), 1);
      rdy_cnt = 0; rdy_edge = 0; fs_s = 0; vs_low_s0 = 0; vs_low_s3 = 0; fs_end = 1'b0;
      first_h = '1; first_v = '1; last_h = '1; last_v = '1;
      rdy_rise = -1; rdy_fall = -1; hs0_f = -1; hs3_f = -1;
      c0_r = -1; c0_f = -1; c3_r = -1; c3_f = -1;
      for (int j = 0; j <= 170; j++) begin
         if (j > 0) @(negedge clk);
         if (j < 170) begin
            if (if_s0.ready) begin
               rdy_cnt++;
               if (rdy_rise < 0) begin
                  rdy_rise = j;
                  first_h = if_s0.pos_H;
                  first_v = if_s0.pos_V;
               end
               last_h = if_s0.pos_H;
               last_v = if_s0.pos_V;
               if (if_s0.pos_H == 10'd0 || if_s0.pos_V == 10'd0) rdy_edge++;
            end else if (rdy_rise >= 0 && rdy_fall < 0) begin
               rdy_fall = j;
            end
            if (if_s0.frame_start) fs_s++;
            if (!vs_s0) vs_low_s0++;
            if (!vs_s3) vs_low_s3++;
            if (hs0_f < 0 && !hs_s0) hs0_f = j;
            if (hs3_f < 0 && !hs_s3) hs3_f = j;
            if (c0_r < 0 && {r_s0, g_s0, b_s0} != 12'h0) c0_r = j;
            else if (c0_r >= 0 && c0_f < 0 && {r_s0, g_s0, b_s0} == 12'h0) c0_f = j;
            if (c3_r < 0 && {r_s3, g_s3, b_s3} != 12'h0) c3_r = j;
            else if (c3_r >= 0 && c3_f < 0 && {r_s3, g_s3, b_s3} == 12'h0) c3_f = j;
         end else begin
            fs_end = if_s0.frame_start;
         end
      end
      check("s_ready_per_frame", rdy_cnt, 40);
      check("s_ready_at_edge", rdy_edge, 0);
      check("s_first_ready_H", first_h, 7);
      check("s_first_ready_V", first_v, 4);
      check("s_last_ready_H", last_h, 14);
      check("s_last_ready_V", last_v, 8);
      check("s_frame_start_cnt", fs_s, 1);
      check("s_frame_period", fs_end, 1);
      check("s0_vsync_low", vs_low_s0, 34);
      check("s3_vsync_low", vs_low_s3, 34);
      check("s_ready_rise", rdy_rise, 75);
      check("s_ready_fall", rdy_fall, 83);
      check("s0_hsync_lat", hs0_f, 1);
      check("s3_hsync_lat", hs3_f, 4);
      check("s0_colour_rise", c0_r, 76);
      check("s0_colour_fall", c0_f, 84);
      check("s3_colour_rise", c3_r, 79);
      check("s3_colour_fall", c3_f, 87);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
